trace_capture_buffer: RTL and testbench

Synthesizable successor to the processor bench probes. It records per-cycle samples of PC, register-file write activity and control state into a parametrised circular buffer. Capture stops a programmable number of samples after a PC-match trigger. TopLevel instantiates it beside the control unit; debug logic or the bench reads the frozen history back through a 1-cycle-latency port.

---
 rtl/trace_capture_buffer.sv | 149 ++++++++++++++
 tb/tb_trace_capture_buffer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_buffer.sv
// Circular trace buffer: records PC / register-write / control-state samples and
// freezes POST_TRIG samples after a PC match. Optional macro TRACE_TIMESTAMP_EN appends a timestamp.
module trace_capture_buffer #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 32,
    parameter int ADDR_W    = 5,
    parameter int STATE_W   = 5,
    parameter int POST_TRIG = 8,
`ifdef TRACE_TIMESTAMP_EN
    localparam int TS_W     = 16,
`else
    localparam int TS_W     = 0,
`endif
    localparam int ENTRY_W  = 2*DATA_W + STATE_W + 4 + TS_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               arm,
    input  logic [DATA_W-1:0]  trig_pc,
    input  logic               sample_valid,
    input  logic [DATA_W-1:0]  pc,
    input  logic [STATE_W-1:0] state,
    input  logic               reg_write,
    input  logic [2:0]         write_reg,
    input  logic [DATA_W-1:0]  write_data,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               rd_valid,
    output logic               armed,
    output logic               triggered,
    output logic               done,
    output logic [ADDR_W:0]    count
);

    if (POST_TRIG > DEPTH - 1) begin : g_bad_post_trig
        $error("POST_TRIG must be <= DEPTH-1");
    end
    if (DEPTH != (1 << ADDR_W) || DEPTH < 4) begin : g_bad_depth
        $error("DEPTH must equal 2**ADDR_W and be >= 4");
    end

    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} fsm_t;

    fsm_t               fsm_q, fsm_nxt;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  post_cnt;
    logic               do_write, do_clear, load_post, dec_post;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] wr_entry;
    logic [ADDR_W-1:0]  rd_idx;
    logic               rd_in_range;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    // Free-running; restarts at arm so stored stamps are cycles since capture start.
    always_ff @(posedge clock) begin
        if (reset || do_clear) ts_q <= '0;
        else                   ts_q <= ts_q + 1'b1;
    end

    assign wr_entry = {pc, state, reg_write, write_reg, write_data, ts_q};
`else
    assign wr_entry = {pc, state, reg_write, write_reg, write_data};
`endif

    // arm is honoured in every state and always beats a same-cycle sample/trigger.
    always_comb begin
        fsm_nxt   = fsm_q;
        do_write  = 1'b0;
        do_clear  = 1'b0;
        load_post = 1'b0;
        dec_post  = 1'b0;
        if (arm) begin
            do_clear = 1'b1;
            fsm_nxt  = ARMED;
        end else begin
            case (fsm_q)
                ARMED: if (sample_valid) begin
                    do_write = 1'b1;
                    if (pc == trig_pc) begin
                        load_post = 1'b1;
                        fsm_nxt   = (POST_TRIG == 0) ? DONE : POST;
                    end
                end
                POST: if (sample_valid) begin
                    do_write = 1'b1;
                    dec_post = 1'b1;
                    if (post_cnt == ADDR_W'(1)) fsm_nxt = DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q     <= IDLE;
            wr_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            triggered <= 1'b0;
            done      <= 1'b0;
        end else begin
            fsm_q <= fsm_nxt;
            done  <= (fsm_nxt == DONE);
            if (do_clear) begin
                wr_ptr    <= '0;
                count     <= '0;
                post_cnt  <= '0;
                triggered <= 1'b0;
            end else begin
                if (do_write) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (count != (ADDR_W+1)'(DEPTH)) count <= count + 1'b1;
                end
                if (load_post) begin
                    post_cnt  <= ADDR_W'(POST_TRIG);
                    triggered <= 1'b1;
                end else if (dec_post) begin
                    post_cnt <= post_cnt - 1'b1;
                end
            end
        end
    end

    assign armed = (fsm_q == ARMED) || (fsm_q == POST);

    // Storage has no reset; writes are blocked while reset is held.
    always_ff @(posedge clock) begin
        if (do_write && !reset) mem[wr_ptr] <= wr_entry;
    end

    // rd_addr is relative to the oldest entry; when full, oldest sits at wr_ptr.
    assign rd_idx      = wr_ptr - count[ADDR_W-1:0] + rd_addr;
    assign rd_in_range = {1'b0, rd_addr} < count;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_in_range ? mem[rd_idx] : '0;
        end
    end

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed bench for trace_capture_buffer (default parameters, DEPTH=32, POST_TRIG=8).
module tb_trace_capture_buffer;

    localparam int BASE_W = 2*16 + 5 + 4;
`ifdef TRACE_TIMESTAMP_EN
    localparam int ENTRY_W = BASE_W + 16;
`else
    localparam int ENTRY_W = BASE_W;
`endif

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               arm = 1'b0;
    logic [15:0]        trig_pc = 16'hFFFF;
    logic               sample_valid = 1'b0;
    logic [15:0]        pc = '0;
    logic [4:0]         state = '0;
    logic               reg_write = 1'b0;
    logic [2:0]         write_reg = '0;
    logic [15:0]        write_data = '0;
    logic               rd_en = 1'b0;
    logic [4:0]         rd_addr = '0;
    logic [ENTRY_W-1:0] rd_data;
    logic               rd_valid;
    logic               armed;
    logic               triggered;
    logic               done;
    logic [5:0]         count;

    int tests = 0;
    int fails = 0;

    trace_capture_buffer dut (
        .clock(clock), .reset(reset), .arm(arm), .trig_pc(trig_pc),
        .sample_valid(sample_valid), .pc(pc), .state(state),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .armed(armed), .triggered(triggered), .done(done), .count(count)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic drive_sample(input int i);
        sample_valid = 1'b1;
        pc           = 16'(i);
        state        = 5'(i);
        reg_write    = 1'b1;
        write_reg    = 3'(i);
        write_data   = 16'(i * 3);
        step();
        sample_valid = 1'b0;
    endtask

    task automatic do_read(input int a);
        rd_en   = 1'b1;
        rd_addr = 5'(a);
        step();
        rd_en   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        tests++; if (count !== 6'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
        tests++; if (armed !== 1'b0 || done !== 1'b0 || triggered !== 1'b0) begin fails++; $display("FAIL reset_flags got a%b d%b t%b exp 000", armed, done, triggered); end
        tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
        do_read(0);
        tests++; if (rd_valid !== 1'b1 || rd_data !== '0) begin fails++; $display("FAIL reset_read got v%b %h exp v1 0", rd_valid, rd_data); end
        step();
        tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL rd_valid_drop got %b exp 0", rd_valid); end
    endtask

    task automatic test_fill();
        logic [BASE_W-1:0] exp_e;
        trig_pc = 16'hFFFF;
        arm_pulse();
        tests++; if (armed !== 1'b1 || count !== 6'd0) begin fails++; $display("FAIL fill_arm got a%b c%0d exp a1 c0", armed, count); end
        for (int i = 0; i < 10; i++) drive_sample(i);
        tests++; if (count !== 6'd10) begin fails++; $display("FAIL fill_count got %0d exp 10", count); end
        tests++; if (armed !== 1'b1 || triggered !== 1'b0) begin fails++; $display("FAIL fill_flags got a%b t%b exp a1 t0", armed, triggered); end
        do_read(3);
        exp_e = {16'd3, 5'd3, 1'b1, 3'd3, 16'd9};
        tests++; if (rd_data[ENTRY_W-1 -: BASE_W] !== exp_e) begin fails++; $display("FAIL fill_entry3 got %h exp %h", rd_data[ENTRY_W-1 -: BASE_W], exp_e); end
        do_read(10);
        tests++; if (rd_valid !== 1'b1 || rd_data !== '0) begin fails++; $display("FAIL fill_oob got v%b %h exp v1 0", rd_valid, rd_data); end
    endtask

    task automatic test_wrap();
        trig_pc = 16'hFFFF;
        arm_pulse();
        for (int i = 0; i < 40; i++) drive_sample(i);
        tests++; if (count !== 6'd32) begin fails++; $display("FAIL wrap_count got %0d exp 32", count); end
        do_read(0);
        tests++; if (rd_data[ENTRY_W-1 -: 16] !== 16'd8) begin fails++; $display("FAIL wrap_addr0 got %0d exp 8", rd_data[ENTRY_W-1 -: 16]); end
        do_read(31);
        tests++; if (rd_data[ENTRY_W-1 -: 16] !== 16'd39) begin fails++; $display("FAIL wrap_addr31 got %0d exp 39", rd_data[ENTRY_W-1 -: 16]); end
        // read the oldest slot while it is being overwritten: old data expected
        rd_en = 1'b1;
        rd_addr = 5'd0;
        drive_sample(40);
        rd_en = 1'b0;
        tests++; if (rd_data[ENTRY_W-1 -: 16] !== 16'd8) begin fails++; $display("FAIL wrap_rw_collide got %0d exp 8", rd_data[ENTRY_W-1 -: 16]); end
        do_read(0);
        tests++; if (rd_data[ENTRY_W-1 -: 16] !== 16'd9 || count !== 6'd32) begin fails++; $display("FAIL wrap_after got pc%0d c%0d exp pc9 c32", rd_data[ENTRY_W-1 -: 16], count); end
    endtask

    task automatic test_trigger();
        trig_pc = 16'd20;
        arm_pulse();
        for (int i = 0; i < 40; i++) begin
            drive_sample(i);
            if (i == 20) begin
                tests++; if (triggered !== 1'b1 || armed !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL trig_fire got t%b a%b d%b exp t1 a1 d0", triggered, armed, done); end
            end
            if (i == 27) begin
                tests++; if (done !== 1'b0) begin fails++; $display("FAIL trig_early_done got %b exp 0", done); end
            end
            if (i == 28) begin
                tests++; if (done !== 1'b1 || armed !== 1'b0 || count !== 6'd29) begin fails++; $display("FAIL trig_done got d%b a%b c%0d exp d1 a0 c29", done, armed, count); end
            end
        end
        tests++; if (count !== 6'd29 || done !== 1'b1) begin fails++; $display("FAIL trig_frozen got c%0d d%b exp c29 d1", count, done); end
        do_read(0);
        tests++; if (rd_data[ENTRY_W-1 -: 16] !== 16'd0) begin fails++; $display("FAIL trig_addr0 got %0d exp 0", rd_data[ENTRY_W-1 -: 16]); end
        do_read(28);
        tests++; if (rd_data[ENTRY_W-1 -: 16] !== 16'd28) begin fails++; $display("FAIL trig_addr28 got %0d exp 28", rd_data[ENTRY_W-1 -: 16]); end
        do_read(29);
        tests++; if (rd_data !== '0 || rd_valid !== 1'b1) begin fails++; $display("FAIL trig_addr29 got v%b %h exp v1 0", rd_valid, rd_data); end
        arm_pulse();
        tests++; if (done !== 1'b0 || armed !== 1'b1 || count !== 6'd0 || triggered !== 1'b0) begin fails++; $display("FAIL rearm_done got d%b a%b c%0d t%b exp d0 a1 c0 t0", done, armed, count, triggered); end
    endtask

    task automatic test_arm_in_post();
        trig_pc = 16'd5;
        arm_pulse();
        for (int i = 0; i < 8; i++) drive_sample(i);
        tests++; if (triggered !== 1'b1 || armed !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL post_state got t%b a%b d%b exp t1 a1 d0", triggered, armed, done); end
        arm = 1'b1;
        drive_sample(100);
        arm = 1'b0;
        tests++; if (triggered !== 1'b0 || count !== 6'd0 || armed !== 1'b1) begin fails++; $display("FAIL post_rearm got t%b c%0d a%b exp t0 c0 a1", triggered, count, armed); end
        trig_pc = 16'd50;
        arm = 1'b1;
        drive_sample(50);
        arm = 1'b0;
        tests++; if (triggered !== 1'b0 || count !== 6'd0) begin fails++; $display("FAIL arm_vs_match got t%b c%0d exp t0 c0", triggered, count); end
        step();
        tests++; if (triggered !== 1'b0 || armed !== 1'b1) begin fails++; $display("FAIL arm_vs_match_late got t%b a%b exp t0 a1", triggered, armed); end
        drive_sample(1);
        do_read(0);
        tests++; if (count !== 6'd1 || rd_data[ENTRY_W-1 -: 16] !== 16'd1) begin fails++; $display("FAIL post_first got c%0d pc%0d exp c1 pc1", count, rd_data[ENTRY_W-1 -: 16]); end
    endtask

    task automatic test_reset_mid_post();
        trig_pc = 16'd2;
        arm_pulse();
        for (int i = 0; i < 4; i++) drive_sample(i);
        reset = 1'b1;
        arm = 1'b1;
        drive_sample(3);
        reset = 1'b0;
        arm = 1'b0;
        tests++; if (armed !== 1'b0 || triggered !== 1'b0 || count !== 6'd0 || done !== 1'b0) begin fails++; $display("FAIL reset_post got a%b t%b c%0d d%b exp 0 0 0 0", armed, triggered, count, done); end
        drive_sample(9);
        tests++; if (count !== 6'd0 || armed !== 1'b0) begin fails++; $display("FAIL idle_no_write got c%0d a%b exp c0 a0", count, armed); end
    endtask

`ifdef TRACE_TIMESTAMP_EN
    task automatic test_timestamp();
        trig_pc = 16'hFFFF;
        arm_pulse();
        step();
        step();
        for (int i = 0; i < 5; i++) drive_sample(i);
        for (int k = 0; k < 5; k++) begin
            do_read(k);
            tests++; if (rd_data[15:0] !== 16'(k + 2)) begin fails++; $display("FAIL ts_%0d got %0d exp %0d", k, rd_data[15:0], k + 2); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_wrap();
        test_trigger();
        test_arm_in_post();
        test_reset_mid_post();
`ifdef TRACE_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
